// File: rtl/axis_cmac_pkg.sv
// Shared definitions for the CMAC-side AXI-Stream blocks: bus widths,
// the frame sanitizer state type and a byte-length to tkeep helper.
package axis_cmac_pkg;

    localparam int AXIS_DATA_W = 512;
    localparam int AXIS_KEEP_W = 64;
    localparam int BYTE_CNT_W  = 16;

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } san_state_e;

    // Low-ones byte mask of length len; any len >= AXIS_KEEP_W yields all ones.
    function automatic logic [AXIS_KEEP_W-1:0] keep_from_len(input logic [BYTE_CNT_W:0] len);
        logic [AXIS_KEEP_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < AXIS_KEEP_W; i++) begin
            if (len > (BYTE_CNT_W+1)'(i)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_keep_popcount.sv
// Combinational population count of a 64-bit tkeep vector (0..64).
module axis_keep_popcount
    import axis_cmac_pkg::*;
(
    input  logic [AXIS_KEEP_W-1:0] keep_i,
    output logic [6:0]             count_o
);

    // Sum of set bits; a simple adder chain the synthesis tool rebalances.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < AXIS_KEEP_W; i++) begin
            count_o = count_o + 7'(keep_i[i]);
        end
    end

endmodule

// File: rtl/axis_tx_frame_sanitizer.sv
// TX frame sanitizer in front of the CMAC clock-crossing FIFO.
// Runt frames are zero-padded to MIN_BYTES, oversize frames are cut at
// MAX_BYTES with the remainder of the input frame discarded.
// Optional statistics counters: define AXIS_TX_SANITIZER_STATS_EN.
//
// Handshake: a beat moves on either side only in a cycle where valid and
// ready are both high at the rising clock edge; the output stage holds
// m_axis_* stable while m_axis_tvalid is high and m_axis_tready is low.
module axis_tx_frame_sanitizer
    import axis_cmac_pkg::*;
#(
    parameter int MIN_BYTES = 60,
    parameter int MAX_BYTES = 9600
) (
    input  logic                   axis_aclk,
    input  logic                   axis_areset,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [31:0]            stat_pkt_cnt,
    output logic [31:0]            stat_pad_cnt,
    output logic [31:0]            stat_trunc_cnt
);

    localparam logic [BYTE_CNT_W:0] MIN_L = (BYTE_CNT_W+1)'(MIN_BYTES);
    localparam logic [BYTE_CNT_W:0] MAX_L = (BYTE_CNT_W+1)'(MAX_BYTES);

    san_state_e             state_q, state_d;
    logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic                   m_tvalid_q;
    logic [AXIS_DATA_W-1:0] m_tdata_q;
    logic [AXIS_KEEP_W-1:0] m_tkeep_q;
    logic                   m_tlast_q;

    logic [6:0]             nb;
    logic [BYTE_CNT_W:0]    cnt_sum;
    logic                   s_accept;
    logic                   emit;
    logic                   trunc_hit;
    logic                   pad_hit;
    logic [AXIS_KEEP_W-1:0] pad_zero;
    logic [AXIS_DATA_W-1:0] data_d;
    logic [AXIS_KEEP_W-1:0] keep_d;
    logic                   last_d;

    axis_keep_popcount u_keep_popcount (
        .keep_i  (s_axis_tkeep),
        .count_o (nb)
    );

    // DROP swallows the tail unconditionally; PASS needs a free output slot.
    assign s_axis_tready = (state_q == DROP) || !m_tvalid_q || m_axis_tready;
    assign s_accept      = s_axis_tvalid && s_axis_tready;

    // Beat classification (truncate beats pad) and next frame/FSM state.
    always_comb begin
        cnt_sum   = {1'b0, byte_cnt_q} + (BYTE_CNT_W+1)'(nb);
        trunc_hit = (cnt_sum >= MAX_L) && (!s_axis_tlast || (cnt_sum > MAX_L));
        pad_hit   = !trunc_hit && (byte_cnt_q == '0) && s_axis_tlast &&
                    ((BYTE_CNT_W+1)'(nb) < MIN_L);
        pad_zero  = keep_from_len(MIN_L) & ~keep_from_len((BYTE_CNT_W+1)'(nb));

        data_d = s_axis_tdata;
        keep_d = s_axis_tkeep;
        last_d = s_axis_tlast;
        if (trunc_hit) begin
            // Never more than nb bytes remain, so the mask fits in this beat.
            keep_d = keep_from_len(MAX_L - {1'b0, byte_cnt_q});
            last_d = 1'b1;
        end else if (pad_hit) begin
            keep_d = keep_from_len(MIN_L);
            last_d = 1'b1;
            for (int b = 0; b < AXIS_KEEP_W; b++) begin
                if (pad_zero[b]) begin
                    data_d[b*8 +: 8] = 8'h00;
                end
            end
        end

        emit       = 1'b0;
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        if (s_accept) begin
            case (state_q)
                PASS: begin
                    emit       = 1'b1;
                    byte_cnt_d = s_axis_tlast ? '0 : cnt_sum[BYTE_CNT_W-1:0];
                    if (trunc_hit && !s_axis_tlast) begin
                        state_d = DROP;
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        state_d    = PASS;
                        byte_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = PASS;
                    byte_cnt_d = '0;
                end
            endcase
        end
    end

    // FSM, byte counter and the registered output beat.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q    <= PASS;
            byte_cnt_q <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            if (emit) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= data_d;
                m_tkeep_q  <= keep_d;
                m_tlast_q  <= last_d;
            end else if (m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tlast  = m_tlast_q;

`ifdef AXIS_TX_SANITIZER_STATS_EN
    logic        pad_flag_q;
    logic        trunc_flag_q;
    logic [31:0] pkt_cnt_q;
    logic [31:0] pad_cnt_q;
    logic [31:0] trunc_cnt_q;

    // Flags travel with the output beat; counters bump when its last beat leaves.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            pad_flag_q   <= 1'b0;
            trunc_flag_q <= 1'b0;
            pkt_cnt_q    <= '0;
            pad_cnt_q    <= '0;
            trunc_cnt_q  <= '0;
        end else begin
            if (emit) begin
                pad_flag_q   <= pad_hit;
                trunc_flag_q <= trunc_hit;
            end
            if (m_tvalid_q && m_axis_tready && m_tlast_q) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
                if (pad_flag_q) begin
                    pad_cnt_q <= pad_cnt_q + 32'd1;
                end
                if (trunc_flag_q) begin
                    trunc_cnt_q <= trunc_cnt_q + 32'd1;
                end
            end
        end
    end

    assign stat_pkt_cnt   = pkt_cnt_q;
    assign stat_pad_cnt   = pad_cnt_q;
    assign stat_trunc_cnt = trunc_cnt_q;
`else
    assign stat_pkt_cnt   = '0;
    assign stat_pad_cnt   = '0;
    assign stat_trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_tx_frame_sanitizer.sv
// Bench for axis_tx_frame_sanitizer: three instances (MAX_BYTES 9600, 128
// and 100), each with its own stimulus and sink, driven by directed vectors.
// Statistics expectations follow AXIS_TX_SANITIZER_STATS_EN.
module tb_axis_tx_frame_sanitizer;

    localparam int NDUT = 3;
    localparam int BW   = 577;  // {tlast, tkeep, tdata}
`ifdef AXIS_TX_SANITIZER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         s_tvalid [NDUT];
    logic         s_tready [NDUT];
    logic [511:0] s_tdata  [NDUT];
    logic [63:0]  s_tkeep  [NDUT];
    logic         s_tlast  [NDUT];
    logic         m_tvalid [NDUT];
    logic         m_tready [NDUT];
    logic [511:0] m_tdata  [NDUT];
    logic [63:0]  m_tkeep  [NDUT];
    logic         m_tlast  [NDUT];
    logic [31:0]  st_pkt   [NDUT];
    logic [31:0]  st_pad   [NDUT];
    logic [31:0]  st_trunc [NDUT];

    axis_tx_frame_sanitizer #(.MIN_BYTES(60), .MAX_BYTES(9600)) dut0 (
        .axis_aclk(clk), .axis_areset(rst),
        .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]), .s_axis_tdata(s_tdata[0]),
        .s_axis_tkeep(s_tkeep[0]), .s_axis_tlast(s_tlast[0]),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]), .m_axis_tdata(m_tdata[0]),
        .m_axis_tkeep(m_tkeep[0]), .m_axis_tlast(m_tlast[0]),
        .stat_pkt_cnt(st_pkt[0]), .stat_pad_cnt(st_pad[0]), .stat_trunc_cnt(st_trunc[0])
    );

    axis_tx_frame_sanitizer #(.MIN_BYTES(60), .MAX_BYTES(128)) dut1 (
        .axis_aclk(clk), .axis_areset(rst),
        .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]), .s_axis_tdata(s_tdata[1]),
        .s_axis_tkeep(s_tkeep[1]), .s_axis_tlast(s_tlast[1]),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]), .m_axis_tdata(m_tdata[1]),
        .m_axis_tkeep(m_tkeep[1]), .m_axis_tlast(m_tlast[1]),
        .stat_pkt_cnt(st_pkt[1]), .stat_pad_cnt(st_pad[1]), .stat_trunc_cnt(st_trunc[1])
    );

    axis_tx_frame_sanitizer #(.MIN_BYTES(60), .MAX_BYTES(100)) dut2 (
        .axis_aclk(clk), .axis_areset(rst),
        .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]), .s_axis_tdata(s_tdata[2]),
        .s_axis_tkeep(s_tkeep[2]), .s_axis_tlast(s_tlast[2]),
        .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready[2]), .m_axis_tdata(m_tdata[2]),
        .m_axis_tkeep(m_tkeep[2]), .m_axis_tlast(m_tlast[2]),
        .stat_pkt_cnt(st_pkt[2]), .stat_pad_cnt(st_pad[2]), .stat_trunc_cnt(st_trunc[2])
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [BW-1:0] exp_q0[$];
    logic [BW-1:0] exp_q1[$];
    logic [BW-1:0] exp_q2[$];

    task automatic check_val(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input int idx, input logic [BW-1:0] beat);
        case (idx)
            0:       exp_q0.push_back(beat);
            1:       exp_q1.push_back(beat);
            default: exp_q2.push_back(beat);
        endcase
    endtask

    function automatic int exp_size(input int idx);
        case (idx)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic pop_check(input int idx, input logic [BW-1:0] obs);
        logic [BW-1:0] e;
        int sz;
        e  = '0;
        sz = exp_size(idx);
        check_val($sformatf("beat_expected_dut%0d", idx), BW'(sz > 0), BW'(1));
        if (sz > 0) begin
            case (idx)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            check_val($sformatf("beat_dut%0d", idx), obs, e);
        end
    endtask

    // Output monitors: sampled on the falling edge, where m_tready is settled.
    for (genvar g = 0; g < NDUT; g++) begin : g_mon
        logic [BW-1:0] cur;
        logic [BW-1:0] held_q;
        logic          stalled_q = 1'b0;
        int            stalls = 0;
        assign cur = {m_tlast[g], m_tkeep[g], m_tdata[g]};
        always @(negedge clk) begin
            if (!rst && stalled_q) begin
                check_val($sformatf("stall_valid_dut%0d", g), BW'(m_tvalid[g]), BW'(1));
                check_val($sformatf("stall_beat_dut%0d", g), cur, held_q);
            end
            if (m_tvalid[g] === 1'b1 && m_tready[g] === 1'b1) begin
                pop_check(g, cur);
            end
            if (!rst && m_tvalid[g] === 1'b1 && m_tready[g] === 1'b0) begin
                held_q    <= cur;
                stalled_q <= 1'b1;
                stalls    <= stalls + 1;
            end else begin
                stalled_q <= 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input int idx, input logic [511:0] d, input logic [63:0] k, input logic l);
        int waited;
        waited        = 0;
        s_tvalid[idx] = 1'b1;
        s_tdata[idx]  = d;
        s_tkeep[idx]  = k;
        s_tlast[idx]  = l;
        forever begin
            @(negedge clk);
            if (s_tready[idx] === 1'b1) break;
            waited++;
            if (waited > 50) begin
                check_val($sformatf("send_timeout_dut%0d", idx), BW'(s_tready[idx]), BW'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid[idx] = 1'b0;
    endtask

    task automatic drain(input int idx);
        step(4);
        check_val($sformatf("drain_dut%0d", idx), BW'(exp_size(idx)), BW'(0));
    endtask

    task automatic check_stats(input int idx, input logic [31:0] pkt, input logic [31:0] pad,
                               input logic [31:0] trunc);
        check_val($sformatf("stat_pkt_dut%0d", idx), BW'(st_pkt[idx]), STATS ? BW'(pkt) : BW'(0));
        check_val($sformatf("stat_pad_dut%0d", idx), BW'(st_pad[idx]), STATS ? BW'(pad) : BW'(0));
        check_val($sformatf("stat_trunc_dut%0d", idx), BW'(st_trunc[idx]), STATS ? BW'(trunc) : BW'(0));
    endtask

    task automatic check_idle(input int idx);
        check_val($sformatf("rst_tvalid_dut%0d", idx), BW'(m_tvalid[idx]), BW'(0));
        check_val($sformatf("rst_beat_dut%0d", idx), {m_tlast[idx], m_tkeep[idx], m_tdata[idx]}, BW'(0));
        check_stats(idx, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [511:0] d [6];
        logic [63:0]  k;
        logic         l;
        int           t0;
        int           acc;
        int           ncyc;

        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            s_tvalid[i] = 1'b0;
            s_tdata[i]  = '0;
            s_tkeep[i]  = '0;
            s_tlast[i]  = 1'b0;
            m_tready[i] = 1'b1;
        end
        step(3);
        for (int i = 0; i < NDUT; i++) check_idle(i);
        check_val("rst_s_tready_dut0", BW'(s_tready[0]), BW'(1));
        rst = 1'b0;
        step(1);

        // Runt: 16 bytes of 0xAA padded to 60, bytes 16..59 zeroed.
        exp_push(0, {1'b1, 64'h0FFF_FFFF_FFFF_FFFF, {4{8'hAA}}, {44{8'h00}}, {16{8'hAA}}});
        send(0, {64{8'hAA}}, 64'h0000_0000_0000_FFFF, 1'b1);
        drain(0);
        check_stats(0, 32'd1, 32'd1, 32'd0);

        // Empty single-beat frame: 60 zero bytes, bytes 60..63 untouched.
        d[0] = rand_data();
        exp_push(0, {1'b1, 64'h0FFF_FFFF_FFFF_FFFF, d[0][511:480], 480'd0});
        send(0, d[0], 64'h0, 1'b1);
        drain(0);
        check_stats(0, 32'd2, 32'd2, 32'd0);

        // Nominal: two back-to-back 134-byte frames, unchanged, 1-cycle latency.
        for (int i = 0; i < 3; i++) d[i] = rand_data();
        t0 = cyc;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) begin
                k = (i == 2) ? 64'h3F : '1;
                l = (i == 2);
                exp_push(0, {l, k, d[i]});
                send(0, d[i], k, l);
                check_val("latency_valid_dut0", BW'(m_tvalid[0]), BW'(1));
                check_val("latency_data_dut0", BW'(m_tdata[0]), BW'(d[i]));
            end
        end
        check_val("nominal_cycles", BW'(cyc - t0), BW'(6));
        drain(0);
        check_stats(0, 32'd4, 32'd2, 32'd0);

        // Oversize at 128 bytes: 5 full beats -> 2 out, then a 64 B frame right after DROP.
        for (int i = 0; i < 6; i++) d[i] = rand_data();
        exp_push(1, {1'b0, {64{1'b1}}, d[0]});
        exp_push(1, {1'b1, {64{1'b1}}, d[1]});
        exp_push(1, {1'b1, {64{1'b1}}, d[5]});
        t0 = cyc;
        for (int i = 0; i < 5; i++) send(1, d[i], '1, (i == 4));
        send(1, d[5], '1, 1'b1);
        check_val("oversize_cycles", BW'(cyc - t0), BW'(6));
        drain(1);
        check_stats(1, 32'd2, 32'd0, 32'd1);

        // Exact limit at 100 bytes: 64 + 36 passes, 64 + 37 is cut to 36.
        d[0] = rand_data();
        d[1] = rand_data();
        exp_push(2, {1'b0, {64{1'b1}}, d[0]});
        exp_push(2, {1'b1, 64'h0000_000F_FFFF_FFFF, d[1]});
        send(2, d[0], '1, 1'b0);
        send(2, d[1], 64'h0000_000F_FFFF_FFFF, 1'b1);
        drain(2);
        check_stats(2, 32'd1, 32'd0, 32'd0);
        exp_push(2, {1'b0, {64{1'b1}}, d[0]});
        exp_push(2, {1'b1, 64'h0000_000F_FFFF_FFFF, d[1]});
        send(2, d[0], '1, 1'b0);
        send(2, d[1], 64'h0000_001F_FFFF_FFFF, 1'b1);
        d[2] = rand_data();
        exp_push(2, {1'b1, {64{1'b1}}, d[2]});
        send(2, d[2], '1, 1'b1);
        drain(2);
        check_stats(2, 32'd3, 32'd0, 32'd1);

        // Backpressure: m_tready toggles 1,0,1,0 during a 4-beat frame.
        for (int i = 0; i < 4; i++) begin
            d[i] = rand_data();
            exp_push(0, {(i == 3), {64{1'b1}}, d[i]});
        end
        acc  = 0;
        ncyc = 0;
        while (acc < 4 && ncyc < 40) begin
            m_tready[0] = (ncyc % 2 == 0);
            s_tvalid[0] = 1'b1;
            s_tdata[0]  = d[acc];
            s_tkeep[0]  = '1;
            s_tlast[0]  = (acc == 3);
            @(negedge clk);
            l = s_tready[0];
            @(posedge clk);
            #1;
            if (l) acc++;
            ncyc++;
        end
        s_tvalid[0] = 1'b0;
        m_tready[0] = 1'b1;
        check_val("bp_beats_accepted", BW'(acc), BW'(4));
        check_val("bp_stalls_seen", BW'(g_mon[0].stalls > 0), BW'(1));
        drain(0);
        check_stats(0, 32'd5, 32'd2, 32'd0);

        // Reset during beat 2 of 3 on the 100-byte instance.
        d[0] = rand_data();
        exp_push(2, {1'b0, {64{1'b1}}, d[0]});
        send(2, d[0], '1, 1'b0);
        s_tvalid[2] = 1'b1;
        s_tdata[2]  = rand_data();
        s_tkeep[2]  = '1;
        s_tlast[2]  = 1'b0;
        rst         = 1'b1;
        step(1);
        s_tvalid[2] = 1'b0;
        @(negedge clk);
        check_idle(2);
        rst = 1'b0;
        step(1);
        d[1] = rand_data();
        exp_push(2, {1'b1, {64{1'b1}}, d[1]});
        send(2, d[1], '1, 1'b1);
        drain(2);
        check_stats(2, 32'd1, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_tx_frame_sanitizer.md
Name: axis_tx_frame_sanitizer

Overview:
- TX-path stage on the user-clock side, directly upstream of the 512-bit AXIS clock-crossing packet FIFO that feeds the CMAC.
- Every frame reaching the FIFO/CMAC is made legal:
  - runt frames are zero-padded to MIN_BYTES;
  - oversize frames are truncated at MAX_BYTES, and the rest of the input frame is discarded.
- Single registered output stage; full throughput; optional frame statistics.

Parameters:
- MIN_BYTES, 60, minimum frame length without FCS; legal range 1..64.
- MAX_BYTES, 9600, maximum frame length without FCS; legal range 64..65535.

Ports:
- axis_aclk  in  1  single clock
- axis_areset  in  1  synchronous, active-high reset
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  512  input data, byte 0 = bits 7:0
- s_axis_tkeep  in  64  input byte enables, contiguous from bit 0
- s_axis_tlast  in  1  input end of frame
- m_axis_tvalid  out  1  output beat valid (to CDC FIFO)
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  512  output data
- m_axis_tkeep  out  64  output byte enables
- m_axis_tlast  out  1  output end of frame
- stat_pkt_cnt  out  32  frames emitted
- stat_pad_cnt  out  32  frames padded
- stat_trunc_cnt  out  32  frames truncated

Behaviour:
- Clocking and reset: one clock, axis_aclk. axis_areset is synchronous and active-high.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, all stat_*=0, state=PASS, byte_cnt=0.
- Reset mid-frame: the partial output beat is lost. The next accepted input beat is treated as the first beat of a new frame.
- Output register: s_axis_tready = !m_axis_tvalid || m_axis_tready. An input beat accepted in cycle N appears at the output in cycle N+1. One beat per cycle is sustained while m_axis_tready=1.
- Output stability: m_axis_* hold stable while m_axis_tvalid && !m_axis_tready.
- Beat byte count: nb = popcount(s_axis_tkeep), 0..64.
- byte_cnt: 16-bit count of bytes accepted so far in the current frame. Cleared after a tlast beat, and cleared when DROP exits.
- State machine has two states, PASS and DROP.
- PASS, accepted beat, three cases in priority order:
  - Truncate: byte_cnt+nb >= MAX_BYTES and (s_axis_tlast=0 or byte_cnt+nb > MAX_BYTES).
    - Emit tkeep = low (MAX_BYTES-byte_cnt) ones, data unchanged, tlast=1, trunc flag set.
    - If s_axis_tlast=0, go to DROP.
    - If s_axis_tlast=1, stay in PASS (tail discarded within the beat).
  - Pad: byte_cnt=0, s_axis_tlast=1 and nb < MIN_BYTES.
    - Emit tkeep = low MIN_BYTES ones.
    - Data bytes nb..MIN_BYTES-1 are forced to 0; bytes 0..nb-1 are unchanged.
    - tlast=1, pad flag set.
  - Otherwise: pass the beat through unchanged.
- nb=0 on a single-beat frame: padded to MIN_BYTES zero bytes.
- Exact MAX_BYTES ending with tlast on that beat: passed through unchanged; not a truncation.
- DROP state:
  - s_axis_tready=1 unconditionally; nothing is emitted.
  - An accepted beat with tlast=1 returns the block to PASS with byte_cnt=0.
  - A new frame's first beat can be accepted in the cycle after the DROP exit.
- Statistics are updated on an output handshake with m_axis_tlast=1:
  - stat_pkt_cnt increments by 1;
  - stat_pad_cnt and stat_trunc_cnt each increment by 1 if their registered flag is set.
  - Counters wrap modulo 2^32.

Optional Feature:
- Macro: AXIS_TX_SANITIZER_STATS_EN.
- Defined: the three statistics counters are implemented as above.
- Undefined: no counter registers exist and stat_* are tied to constant 0. The datapath is identical in both builds.

Decomposition:
- Shared package axis_cmac_pkg holds:
  - AXIS_DATA_W=512, AXIS_KEEP_W=64;
  - BYTE_CNT_W=16;
  - the state enum {PASS, DROP};
  - function keep_from_len(len) returning a 64-bit low-ones mask, saturating at 64.
- Sub-module axis_keep_popcount: combinational 64-bit popcount producing a 7-bit result. It is reusable by other CMAC-path blocks.

Test Plan:
- Runt: single beat, tkeep=0x0000_0000_0000_FFFF (16 B), tlast=1, data all 0xAA → one output beat, tkeep=0x0FFF_FFFF_FFFF_FFFF, bytes 16..59 = 0x00, bytes 0..15 = 0xAA, stat_pad_cnt=1.
- Nominal frame of 2 full beats + 6 bytes, back-to-back with a second identical frame, m_axis_tready=1 → 6 output beats on 6 consecutive cycles, identical to input, 1-cycle latency.
- Oversize with MAX_BYTES=128: 5 full beats, tlast on beat 5 → 2 output beats, second beat tlast=1 with full tkeep; input beats 3..5 consumed with tready=1; stat_trunc_cnt=1.
- Exact limit with MAX_BYTES=100: beat 2 has tkeep of 36 ones and tlast=1 → passed unchanged, stat_trunc_cnt=0. Repeated with 37 ones → beat 2 output tkeep = 36 ones.
- Backpressure: m_axis_tready toggling 1010… during a 4-beat frame → no beat lost or duplicated; m_axis_* stable while stalled.
- Reset: assert axis_areset during beat 2 of 3 → all outputs 0 the next cycle. A subsequent single-beat 64 B frame passes unchanged with stat_pkt_cnt=1.
